// File: rtl/adc_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adc_scheduler: frame-start/command sequencer for the serial ADC,  |
// | tags each returned result with the channel it really belongs to.  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module adc_scheduler #(
    parameter logic [15:0] DIVISOR = 16'd1000,
    parameter logic [7:0]  TIMEOUT = 8'd64,
    parameter logic        RANGE   = 1'b0,
    parameter logic        CODING  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  ch_mask,
    input  logic        clr_status,
    input  logic        adc_valid,
    input  logic [11:0] adc_data,
    output logic        pulse,
    output logic [15:0] command,
    output logic [11:0] sample,
    output logic [2:0]  sample_ch,
    output logic        sample_valid,
    output logic        overrun,
    output logic        timeout_err
);

    localparam logic [1:0] C_IDLE      = 2'd0;
    localparam logic [1:0] C_WAIT_TICK = 2'd1;
    localparam logic [1:0] C_ISSUE     = 2'd2;
    localparam logic [1:0] C_WAIT_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [2:0]  cur_ch_q, cur_ch_d;
    logic [2:0]  last_ch_q, last_ch_d;
    logic [2:0]  prev_tag_q, prev_tag_d;
    logic        prev_tag_valid_q, prev_tag_valid_d;
    logic        first_q, first_d;
    logic [15:0] command_q, command_d;
    logic [11:0] sample_q, sample_d;
    logic [2:0]  sample_ch_q, sample_ch_d;
    logic        sample_valid_q, sample_valid_d;
    logic        overrun_q, overrun_d;
    logic        timeout_err_q, timeout_err_d;

    logic        w_tick;
    logic [2:0]  w_start;
    logic [2:0]  w_idx;
    logic [2:0]  w_pick;
    logic        w_found;

    assign w_tick = enable && (cnt_q == DIVISOR - 16'd1);

    // Round-robin search: begins just after the last served channel, or at 0 on the first pick.
    always_comb begin
        w_start = first_q ? 3'd0 : last_ch_q + 3'd1;
        w_pick  = 3'd0;
        w_found = 1'b0;
        w_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            w_idx = w_start + 3'(i);
            if (!w_found && ch_mask[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        tmo_d            = tmo_q;
        cur_ch_d         = cur_ch_q;
        last_ch_d        = last_ch_q;
        prev_tag_d       = prev_tag_q;
        prev_tag_valid_d = prev_tag_valid_q;
        first_d          = first_q;
        command_d        = command_q;
        sample_d         = sample_q;
        sample_ch_d      = sample_ch_q;
        sample_valid_d   = 1'b0;

        if (!enable || w_tick) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        // Set beats clear when both land in the same cycle.
        overrun_d     = (overrun_q && !clr_status) ||
                        (w_tick && (state_q == C_ISSUE || state_q == C_WAIT_DONE));
        timeout_err_d = timeout_err_q && !clr_status;

        case (state_q)
            C_IDLE: begin
                prev_tag_valid_d = 1'b0;
                first_d          = 1'b1;
                if (enable) begin
                    state_d = C_WAIT_TICK;
                end
            end
            C_WAIT_TICK: begin
                if (!enable) begin
                    state_d = C_IDLE;
                end else if (w_tick && w_found) begin
                    cur_ch_d  = w_pick;
                    first_d   = 1'b0;
                    command_d = {1'b1, 1'b0, 1'b0, w_pick, 2'b11, 1'b0, 1'b0,
                                 RANGE, CODING, 4'b0000};
                    state_d   = C_ISSUE;
                end
            end
            C_ISSUE: begin
                tmo_d   = 8'd1;
                state_d = C_WAIT_DONE;
            end
            default: begin
                if (adc_valid) begin
                    // This result answers the previous frame's command, not the current one.
                    if (prev_tag_valid_q) begin
                        sample_d       = adc_data;
                        sample_ch_d    = prev_tag_q;
                        sample_valid_d = 1'b1;
                    end
                    prev_tag_d       = cur_ch_q;
                    prev_tag_valid_d = 1'b1;
                    last_ch_d        = cur_ch_q;
                    state_d          = enable ? C_WAIT_TICK : C_IDLE;
                end else if (tmo_q == TIMEOUT - 8'd1) begin
                    timeout_err_d    = 1'b1;
                    prev_tag_valid_d = 1'b0;
                    state_d          = enable ? C_WAIT_TICK : C_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= C_IDLE;
            cnt_q            <= 16'd0;
            tmo_q            <= 8'd0;
            cur_ch_q         <= 3'd0;
            last_ch_q        <= 3'd0;
            prev_tag_q       <= 3'd0;
            prev_tag_valid_q <= 1'b0;
            first_q          <= 1'b0;
            command_q        <= 16'h0000;
            sample_q         <= 12'd0;
            sample_ch_q      <= 3'd0;
            sample_valid_q   <= 1'b0;
            overrun_q        <= 1'b0;
            timeout_err_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            tmo_q            <= tmo_d;
            cur_ch_q         <= cur_ch_d;
            last_ch_q        <= last_ch_d;
            prev_tag_q       <= prev_tag_d;
            prev_tag_valid_q <= prev_tag_valid_d;
            first_q          <= first_d;
            command_q        <= command_d;
            sample_q         <= sample_d;
            sample_ch_q      <= sample_ch_d;
            sample_valid_q   <= sample_valid_d;
            overrun_q        <= overrun_d;
            timeout_err_q    <= timeout_err_d;
        end
    end

    assign pulse        = (state_q == C_ISSUE);
    assign command      = command_q;
    assign sample       = sample_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = sample_valid_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_adc_scheduler: random/directed bench with scoreboard for the   |
// | ADC scheduler. Revision: 1.0                                      |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_adc_scheduler;

    localparam int DIV = 20;
    localparam int TMO = 64;
    localparam bit RNG = 1'b1;
    localparam bit COD = 1'b0;

    localparam int PH_IDLE  = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_ISSUE = 2;
    localparam int PH_BUSY  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic        clr_status = 1'b0;
    logic        adc_valid = 1'b0;
    logic [11:0] adc_data = 12'h000;
    logic        pulse;
    logic [15:0] command;
    logic [11:0] sample;
    logic [2:0]  sample_ch;
    logic        sample_valid;
    logic        overrun;
    logic        timeout_err;

    adc_scheduler #(
        .DIVISOR(16'(DIV)),
        .TIMEOUT(8'(TMO)),
        .RANGE  (RNG),
        .CODING (COD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .ch_mask     (ch_mask),
        .clr_status  (clr_status),
        .adc_valid   (adc_valid),
        .adc_data    (adc_data),
        .pulse       (pulse),
        .command     (command),
        .sample      (sample),
        .sample_ch   (sample_ch),
        .sample_valid(sample_valid),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] data;
        logic [2:0]  ch;
        longint      due;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: tracks the frame life cycle and who owns the next result.
    int m_ph, m_cnt, m_last, m_cur, m_own, m_since, m_cmd_ch;
    bit m_first, m_own_v, m_ov, m_to, m_cmd_v;

    function automatic logic [15:0] cmd_of(input int ch);
        return 16'h8300 | (16'(ch) << 10) | (16'(RNG) << 5) | (16'(COD) << 4);
    endfunction

    function automatic int choose();
        int lo = -1;
        int above = -1;
        for (int c = 0; c < 8; c++) begin
            if (ch_mask[c]) begin
                if (lo < 0) lo = c;
                if (above < 0 && !m_first && c > m_last) above = c;
            end
        end
        return (above >= 0) ? above : lo;
    endfunction

    task automatic model_reset();
        m_ph = PH_IDLE; m_cnt = 0; m_last = 0; m_cur = 0; m_own = 0; m_since = 0;
        m_cmd_ch = 0; m_first = 0; m_own_v = 0; m_ov = 0; m_to = 0; m_cmd_v = 0;
    endtask

    task automatic model_advance();
        bit tick, ov_set, to_set;
        tick   = enable && (m_cnt == DIV - 1);
        ov_set = tick && (m_ph == PH_ISSUE || m_ph == PH_BUSY);
        to_set = 1'b0;
        case (m_ph)
            PH_IDLE: begin
                m_own_v = 0;
                m_first = 1;
                if (enable) m_ph = PH_WAIT;
            end
            PH_WAIT: begin
                if (!enable) m_ph = PH_IDLE;
                else if (tick && ch_mask != 8'h00) begin
                    m_cur = choose(); m_first = 0;
                    m_cmd_v = 1; m_cmd_ch = m_cur;
                    m_ph = PH_ISSUE;
                end
            end
            PH_ISSUE: begin
                m_since = 1;
                m_ph = PH_BUSY;
            end
            default: begin
                if (adc_valid) begin
                    if (m_own_v) sb.push_back('{adc_data, 3'(m_own), cyc + 1});
                    m_own = m_cur; m_own_v = 1; m_last = m_cur;
                    m_ph = enable ? PH_WAIT : PH_IDLE;
                end else if (m_since + 1 == TMO) begin
                    to_set = 1; m_own_v = 0;
                    m_ph = enable ? PH_WAIT : PH_IDLE;
                end else begin
                    m_since++;
                end
            end
        endcase
        m_ov  = ov_set || (m_ov && !clr_status);
        m_to  = to_set || (m_to && !clr_status);
        m_cnt = (!enable || tick) ? 0 : m_cnt + 1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (reset) model_reset();
            chk("pulse", 16'(pulse), 16'(m_ph == PH_ISSUE));
            chk("command", command, m_cmd_v ? cmd_of(m_cmd_ch) : 16'h0000);
            chk("overrun", 16'(overrun), 16'(m_ov));
            chk("timeout_err", 16'(timeout_err), 16'(m_to));
            if (!reset) model_advance();
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                chk("sample_valid_in_reset", 16'(sample_valid), 16'h0);
            end else begin
                if (sample_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_sample_valid", 16'(sample_valid), 16'h0);
                    end else begin
                        chk("sample", 16'(sample), 16'(sb[0].data));
                        chk("sample_ch", 16'(sample_ch), 16'(sb[0].ch));
                        void'(sb.pop_front());
                    end
                end
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    chk("missing_sample_valid", 16'(sample_valid), 16'h1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Frame engine: answers eng_mode clocks after pulse (-1 never, -2 random).
    int eng_mode = 17;
    bit eng_rand_data = 0;
    int cd = -1;
    logic [2:0] eng_ch = 3'd0;

    function automatic int pick_delay();
        int r;
        if (eng_mode >= 0) return eng_mode;
        if (eng_mode == -1) return -1;
        r = $urandom_range(0, 19);
        if (r < 14) return $urandom_range(2, 18);
        if (r < 18) return $urandom_range(21, 40);
        return -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #2;
            adc_valid = 1'b0;
            if (reset) begin
                cd = -1;
            end else if (pulse) begin
                cd = pick_delay();
                eng_ch = command[12:10];
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    adc_valid = 1'b1;
                    adc_data  = eng_rand_data ? 12'($urandom) : 12'h100 + 12'(eng_ch);
                    cd = -1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_pulse();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (pulse) seen = 1;
        end
        if (!seen) chk("wait_pulse_timeout", 16'(seen), 16'h1);
    endtask

    initial begin
        run(3);
        reset = 1'b0;
        enable = 1'b1;
        ch_mask = 8'h0B;
        eng_mode = 17;
        run(170);
        eng_mode = 25;
        run(80);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        eng_mode = -1;
        run(150);
        eng_mode = 17;
        run(100);
        ch_mask = 8'h00;
        run(70);
        ch_mask = 8'h80;
        run(120);
        // Asynchronous reset in the middle of a frame
        ch_mask = 8'h0B;
        wait_pulse();
        run(5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(120);
        // Drop enable while a frame is in flight
        wait_pulse();
        run(5);
        enable = 1'b0;
        run(60);
        enable = 1'b1;
        run(80);
        // Randomised traffic
        eng_mode = -2;
        eng_rand_data = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) ch_mask = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            clr_status = ($urandom_range(0, 29) == 0);
            step();
        end
        clr_status = 1'b0;
        enable = 1'b1;
        run(100);
        chk("scoreboard_drain", 16'(sb.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
